regfile_wb_arbiter: RTL and testbench

//  Owns the single write port of RegisterFile. After reset it sweeps x1..x31 to zero (the regfile has no reset),

---
 rtl/regfile_wb_arbiter_if.sv | 39 +++
 rtl/regfile_wb_arbiter.sv | 109 ++++++++++
 tb/tb_regfile_wb_arbiter.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/regfile_wb_arbiter_if.sv
// Writeback/scoreboard bundle between the ALU/LSU/issue side and the
// register-file write-port arbiter.
interface regfile_wb_arbiter_if #(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 5
);
  logic              alu_valid;
  logic [ADDR_W-1:0] alu_rd;
  logic [XLEN-1:0]   alu_data;
  logic              alu_ready;
  logic              lsu_valid;
  logic [ADDR_W-1:0] lsu_rd;
  logic [XLEN-1:0]   lsu_data;
  logic              lsu_ready;
  logic              rf_we;
  logic [ADDR_W-1:0] rf_w;
  logic [XLEN-1:0]   rf_data_in;
  logic              sb_set_valid;
  logic [ADDR_W-1:0] sb_set_rd;
  logic [ADDR_W-1:0] sb_rs1;
  logic [ADDR_W-1:0] sb_rs2;
  logic              sb_rs1_pend;
  logic              sb_rs2_pend;
  logic              init_done;

  modport master (
    output alu_valid, alu_rd, alu_data, lsu_valid, lsu_rd, lsu_data,
           sb_set_valid, sb_set_rd, sb_rs1, sb_rs2,
    input  alu_ready, lsu_ready, rf_we, rf_w, rf_data_in,
           sb_rs1_pend, sb_rs2_pend, init_done
  );

  modport slave (
    input  alu_valid, alu_rd, alu_data, lsu_valid, lsu_rd, lsu_data,
           sb_set_valid, sb_set_rd, sb_rs1, sb_rs2,
    output alu_ready, lsu_ready, rf_we, rf_w, rf_data_in,
           sb_rs1_pend, sb_rs2_pend, init_done
  );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Owns the register-file write port: zero-sweeps x1..x(NREGS-1) after reset,
// then round-robins ALU/LSU writebacks and tracks pending destinations.
module regfile_wb_arbiter #(
  parameter int XLEN           = 32,
  parameter int NREGS          = 32,
  parameter int ADDR_W         = 5,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic               clk,
  input  logic               resetn,
  regfile_wb_arbiter_if.slave bus
);

  typedef enum logic {S_CLEAR, S_RUN} state_e;
  typedef enum logic {SRC_ALU, SRC_LSU} src_e;

  state_e            state_q, state_d;
  src_e              last_grant_q, last_grant_d;
  logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
  logic              rf_we_q, rf_we_d;
  logic [ADDR_W-1:0] rf_w_q, rf_w_d;
  logic [XLEN-1:0]   rf_data_q, rf_data_d;
  logic [NREGS-1:1]  pending_q, pending_d;
  logic              init_done_q;

  logic              run;
  logic              grant_alu, grant_lsu;
  logic [ADDR_W-1:0] wb_rd;
  logic [XLEN-1:0]   wb_data;
  logic [NREGS-1:0]  pend_vec;

  assign run       = (state_q == S_RUN);
  // On a tie the source that did not win last time goes first.
  assign grant_alu = run && bus.alu_valid && (!bus.lsu_valid || last_grant_q == SRC_LSU);
  assign grant_lsu = run && bus.lsu_valid && !grant_alu;
  assign wb_rd     = grant_alu ? bus.alu_rd   : bus.lsu_rd;
  assign wb_data   = grant_alu ? bus.alu_data : bus.lsu_data;
  assign pend_vec  = {pending_q, 1'b0};

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    clr_cnt_d    = clr_cnt_q;
    rf_we_d      = 1'b0;
    rf_w_d       = rf_w_q;
    rf_data_d    = rf_data_q;
    pending_d    = pending_q;

    unique case (state_q)
      S_CLEAR: begin
        rf_we_d   = 1'b1;
        rf_w_d    = clr_cnt_q;
        rf_data_d = '0;
        clr_cnt_d = clr_cnt_q + 1'b1;
        if (clr_cnt_q == ADDR_W'(NREGS - 1)) state_d = S_RUN;
      end
      S_RUN: begin
        if (grant_alu || grant_lsu) begin
          last_grant_d = grant_alu ? SRC_ALU : SRC_LSU;
          rf_we_d      = (wb_rd != '0);
          rf_w_d       = wb_rd;
          rf_data_d    = wb_data;
        end
        // Clear first so a same-cycle issue to the same rd keeps it pending.
        for (int i = 1; i < NREGS; i++) begin
          if ((grant_alu || grant_lsu) && wb_rd == ADDR_W'(i)) pending_d[i] = 1'b0;
          if (bus.sb_set_valid && bus.sb_set_rd == ADDR_W'(i)) pending_d[i] = 1'b1;
        end
      end
      default: state_d = S_RUN;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= CLEAR_ON_RESET ? S_CLEAR : S_RUN;
      last_grant_q <= SRC_LSU;
      clr_cnt_q    <= ADDR_W'(1);
      rf_we_q      <= 1'b0;
      rf_w_q       <= '0;
      rf_data_q    <= '0;
      pending_q    <= '0;
      init_done_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      clr_cnt_q    <= clr_cnt_d;
      rf_we_q      <= rf_we_d;
      rf_w_q       <= rf_w_d;
      rf_data_q    <= rf_data_d;
      pending_q    <= pending_d;
      init_done_q  <= init_done_q || run;
    end
  end

  assign bus.alu_ready  = grant_alu;
  assign bus.lsu_ready  = grant_lsu;
  assign bus.rf_we      = rf_we_q;
  assign bus.rf_w       = rf_w_q;
  assign bus.rf_data_in = rf_data_q;
  assign bus.init_done  = init_done_q;

  // The write sitting in rf_we/rf_w is not yet readable from the regfile.
  assign bus.sb_rs1_pend = run && (bus.sb_rs1 != '0) &&
                           (pend_vec[bus.sb_rs1] || (rf_we_q && rf_w_q == bus.sb_rs1));
  assign bus.sb_rs2_pend = run && (bus.sb_rs2 != '0) &&
                           (pend_vec[bus.sb_rs2] || (rf_we_q && rf_w_q == bus.sb_rs2));

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: sweep, arbitration, scoreboard, reset abort.
module tb_regfile_wb_arbiter;
  localparam int XLEN   = 32;
  localparam int NREGS  = 32;
  localparam int ADDR_W = 5;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  regfile_wb_arbiter_if #(.XLEN(XLEN), .ADDR_W(ADDR_W)) bus ();

  regfile_wb_arbiter #(
    .XLEN(XLEN), .NREGS(NREGS), .ADDR_W(ADDR_W), .CLEAR_ON_RESET(1'b1)
  ) dut (
    .clk   (clk),
    .resetn(resetn),
    .bus   (bus.slave)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%08h exp=0x%08h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Advance one clock; return at the following falling edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    bus.alu_valid    = 1'b0; bus.alu_rd = '0; bus.alu_data = '0;
    bus.lsu_valid    = 1'b0; bus.lsu_rd = '0; bus.lsu_data = '0;
    bus.sb_set_valid = 1'b0; bus.sb_set_rd = '0;
    bus.sb_rs1       = '0;   bus.sb_rs2 = '0;
  endtask

  initial begin
    bit found;
    idle_inputs();
    // Requests during reset and sweep must never be accepted.
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd2; bus.alu_data = 32'h1111_1111;
    bus.sb_set_valid = 1'b1; bus.sb_set_rd = 5'd3;
    #12;
    check_eq("rst_rf_we",     bus.rf_we, 0);
    check_eq("rst_rf_w",      bus.rf_w, 0);
    check_eq("rst_rf_data",   bus.rf_data_in, 0);
    check_eq("rst_init_done", bus.init_done, 0);
    check_eq("rst_alu_ready", bus.alu_ready, 0);

    // ---- zero sweep ----
    @(negedge clk);
    resetn = 1'b1;
    for (int k = 1; k <= 31; k++) begin
      step();
      check_eq($sformatf("sweep_we_%0d", k),   bus.rf_we, 1);
      check_eq($sformatf("sweep_w_%0d", k),    bus.rf_w, k);
      check_eq($sformatf("sweep_data_%0d", k), bus.rf_data_in, 0);
      check_eq($sformatf("sweep_init_%0d", k), bus.init_done, 0);
      if (k <= 30) begin
        bus.sb_rs1 = ADDR_W'(k);
        #1;
        check_eq($sformatf("sweep_alu_rdy_%0d", k), bus.alu_ready, 0);
        check_eq($sformatf("sweep_pend_%0d", k),    bus.sb_rs1_pend, 0);
      end
      if (k == 30) idle_inputs();
    end
    step();
    check_eq("init_done_32", bus.init_done, 1);
    check_eq("post_sweep_we", bus.rf_we, 0);
    bus.sb_rs1 = 5'd3;
    #1;
    check_eq("sweep_set_ignored", bus.sb_rs1_pend, 0);

    // ---- ALU only ----
    idle_inputs();
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd5; bus.alu_data = 32'hDEAD_BEEF;
    #1;
    check_eq("alu_only_ready", bus.alu_ready, 1);
    check_eq("alu_only_lsu_rdy", bus.lsu_ready, 0);
    step();
    idle_inputs();
    check_eq("alu_only_we",   bus.rf_we, 1);
    check_eq("alu_only_w",    bus.rf_w, 5);
    check_eq("alu_only_data", bus.rf_data_in, 32'hDEAD_BEEF);

    // ---- LSU only (leaves last grant = LSU) ----
    bus.lsu_valid = 1'b1; bus.lsu_rd = 5'd6; bus.lsu_data = 32'h1234_5678;
    #1;
    check_eq("lsu_only_ready", bus.lsu_ready, 1);
    check_eq("lsu_only_alu_rdy", bus.alu_ready, 0);
    step();
    idle_inputs();
    check_eq("lsu_only_w",    bus.rf_w, 6);
    check_eq("lsu_only_data", bus.rf_data_in, 32'h1234_5678);

    // ---- both valid: ALU, LSU, ALU, LSU ----
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd3; bus.alu_data = 32'hAAAA_0003;
    bus.lsu_valid = 1'b1; bus.lsu_rd = 5'd4; bus.lsu_data = 32'hBBBB_0004;
    for (int i = 0; i < 4; i++) begin
      #1;
      check_eq($sformatf("rr_alu_rdy_%0d", i), bus.alu_ready, (i % 2 == 0));
      check_eq($sformatf("rr_lsu_rdy_%0d", i), bus.lsu_ready, (i % 2 == 1));
      step();
      check_eq($sformatf("rr_w_%0d", i), bus.rf_w, (i % 2 == 0) ? 3 : 4);
      check_eq($sformatf("rr_data_%0d", i), bus.rf_data_in,
               (i % 2 == 0) ? 32'hAAAA_0003 : 32'hBBBB_0004);
    end
    idle_inputs();
    step();
    check_eq("idle_we",   bus.rf_we, 0);
    check_eq("idle_hold", bus.rf_w, 4);

    // ---- scoreboard set / clear via LSU ----
    bus.sb_set_valid = 1'b1; bus.sb_set_rd = 5'd7; bus.sb_rs1 = 5'd7; bus.sb_rs2 = 5'd8;
    step();
    bus.sb_set_valid = 1'b0;
    #1;
    check_eq("sb7_pend",   bus.sb_rs1_pend, 1);
    check_eq("sb8_nopend", bus.sb_rs2_pend, 0);
    bus.lsu_valid = 1'b1; bus.lsu_rd = 5'd7; bus.lsu_data = 32'h0000_0077;
    #1;
    check_eq("sb7_lsu_rdy", bus.lsu_ready, 1);
    step();
    bus.lsu_valid = 1'b0;
    #1;
    check_eq("sb7_pend_wbstage", bus.sb_rs1_pend, 1);
    check_eq("sb7_wb_w", bus.rf_w, 7);
    step();
    #1;
    check_eq("sb7_cleared", bus.sb_rs1_pend, 0);

    // ---- same-cycle set and clear: set wins ----
    bus.sb_set_valid = 1'b1; bus.sb_set_rd = 5'd9; bus.sb_rs1 = 5'd9;
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd9; bus.alu_data = 32'h0000_0099;
    #1;
    check_eq("sb9_alu_rdy", bus.alu_ready, 1);
    step();
    idle_inputs();
    bus.sb_rs1 = 5'd9;
    step();
    #1;
    check_eq("sb9_set_wins", bus.sb_rs1_pend, 1);

    // ---- rd == 0 writeback ----
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd0; bus.alu_data = 32'h0000_0005;
    bus.sb_rs2 = 5'd0;
    #1;
    check_eq("x0_alu_rdy", bus.alu_ready, 1);
    step();
    bus.alu_valid = 1'b0;
    #1;
    check_eq("x0_no_we", bus.rf_we, 0);
    check_eq("x0_query", bus.sb_rs2_pend, 0);

    // ---- reset mid-sweep ----
    @(negedge clk);
    resetn = 1'b0;
    #2;
    check_eq("re_rst_init", bus.init_done, 0);
    @(negedge clk);
    resetn = 1'b1;
    found = 1'b0;
    for (int c = 0; c < 40 && !found; c++) begin
      step();
      if (bus.rf_w == 5'd12) found = 1'b1;
    end
    check_eq("reach_w12", found, 1);
    resetn = 1'b0;
    #1;
    check_eq("abort_we", bus.rf_we, 0);
    check_eq("abort_w",  bus.rf_w, 0);
    @(negedge clk);
    resetn = 1'b1;
    step();
    check_eq("restart_we", bus.rf_we, 1);
    check_eq("restart_w",  bus.rf_w, 1);
    bus.sb_rs1 = 5'd9;
    #1;
    check_eq("restart_pend9", bus.sb_rs1_pend, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end
endmodule
